// File: rtl/mul_div_unit_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
//   - funct3 encodings of the M extension (F3_MUL .. F3_REMU)
//   - FSM state encoding (state_t)
//   - DIV_ITERS: restoring-division iterations per divide (one quotient bit each)
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MUL     = 2'b01,
        ST_DIV_RUN = 2'b10,
        ST_DIV_FIX = 2'b11
    } state_t;

    localparam int         DIV_ITERS     = 32;
    localparam logic [5:0] DIV_ITERS_CNT = 6'(DIV_ITERS);

endpackage

// File: rtl/mul_div_unit_div_step.sv
// div_step: one combinational restoring-division iteration.
// Ports:
//   rem_in   [32:0] - partial remainder before this step
//   quo_in   [31:0] - quotient register; its MSB is the next dividend bit
//   divisor  [31:0] - unsigned divisor magnitude
//   rem_out  [32:0] - partial remainder after the trial subtract (restored if negative)
//   quo_out  [31:0] - quotient shifted left with the new quotient bit in bit 0
module div_step (
    input  logic [32:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [32:0] rem_out,
    output logic [31:0] quo_out
);

    logic [33:0] shifted;
    logic [34:0] trial;
    logic        fits;

    always_comb begin
        // Shift remainder:quotient left by one; the dividend bit enters the remainder.
        shifted = {rem_in, quo_in[31]};
        // Extra headroom bit so the borrow is unambiguous for any 34-bit shifted value.
        trial   = {1'b0, shifted} - {3'b000, divisor};
        fits    = (trial[34:33] == 2'b00);
        if (fits) begin
            rem_out = trial[32:0];
            quo_out = {quo_in[30:0], 1'b1};
        end else begin
            rem_out = shifted[32:0];
            quo_out = {quo_in[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU).
// Multiply takes 2 cycles from START; divide is a 32-step restoring divider with 34-cycle latency.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the
// iteration and finish with multiply latency; results are identical either way.
// Ports:
//   CLK        - clock, rising edge
//   RESET      - asynchronous active-high reset
//   START      - launch an operation (accepted only when idle and not busy)
//   FLUSH      - abandon any in-flight operation; also wins over a same-cycle START
//   FUNCT3     - M-extension funct3 selecting the operation
//   OPERAND_A  - rs1 (multiplicand / dividend)
//   OPERAND_B  - rs2 (multiplier / divisor)
//   RESULT     - registered result, changes only on the edge that raises DONE
//   BUSY       - high from the cycle after an accepted START through the DONE cycle
//   DONE       - one-cycle pulse marking RESULT valid
// Handshake: START is a request strobe sampled on a rising edge while BUSY is low;
// the consumer stalls while BUSY is high and takes RESULT in the cycle DONE is high.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            FLUSH,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY,
    output logic            DONE
);

    state_t      state_q, state_d;
    logic [2:0]  f3_q;
    logic [31:0] a_q, b_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [5:0]  cnt_q;
    logic        qneg_q, rneg_q;
    logic [31:0] result_q;
    logic        busy_q, done_q;

    // FSM control decodes
    logic accept, do_step, fin_mul, fin_div, early;

    // Capture-time operand conditioning
    logic        signed_div, a_neg, b_neg, b_zero;
    logic [31:0] a_abs, b_abs;

    // Datapath intermediates
    logic [32:0] rem_n;
    logic [31:0] quo_n;
    logic        a_sx, b_sx;
    logic [63:0] a_m, b_m, prod;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        signed_div = FUNCT3[2] & ~FUNCT3[0];
        a_neg      = signed_div & OPERAND_A[31];
        b_neg      = signed_div & OPERAND_B[31];
        a_abs      = a_neg ? (32'd0 - OPERAND_A) : OPERAND_A;
        b_abs      = b_neg ? (32'd0 - OPERAND_B) : OPERAND_B;
        b_zero     = (OPERAND_B == 32'd0);
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic ovf;
    always_comb begin
        ovf   = signed_div && (OPERAND_A == 32'h8000_0000) && (OPERAND_B == 32'hFFFF_FFFF);
        early = FUNCT3[2] & (b_zero | ovf);
    end
`else
    always_comb early = 1'b0;
`endif

    // "Idle" for launch purposes excludes the DONE cycle, where the FSM is
    // already back in ST_IDLE but BUSY is still high.
    assign accept = (state_q == ST_IDLE) && !busy_q && START && !FLUSH;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        do_step = 1'b0;
        fin_mul = 1'b0;
        fin_div = 1'b0;
        if (FLUSH) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!FUNCT3[2])  state_d = ST_MUL;
                        else if (early)  state_d = ST_DIV_FIX;
                        else             state_d = ST_DIV_RUN;
                    end
                end
                ST_MUL: begin
                    fin_mul = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_DIV_RUN: begin
                    do_step = 1'b1;
                    if (cnt_q == 6'd1) state_d = ST_DIV_FIX;
                end
                ST_DIV_FIX: begin
                    fin_div = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    div_step u_div_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (b_q),
        .rem_out (rem_n),
        .quo_out (quo_n)
    );

    // 64-bit product with per-op signedness: sign-extending to 64 bits makes the
    // low 64 bits of an unsigned multiply the correct signed/mixed product.
    always_comb begin
        a_sx = ((f3_q == F3_MULH) || (f3_q == F3_MULHSU)) & a_q[31];
        b_sx = (f3_q == F3_MULH) & b_q[31];
        a_m  = {{32{a_sx}}, a_q};
        b_m  = {{32{b_sx}}, b_q};
        prod = a_m * b_m;
    end

    always_comb begin
        quo_fix = qneg_q ? (32'd0 - quo_q) : quo_q;
        rem_fix = rneg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            f3_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            cnt_q    <= 6'd0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= fin_mul | fin_div;

            if (FLUSH)       busy_q <= 1'b0;
            else if (accept) busy_q <= 1'b1;
            else if (done_q) busy_q <= 1'b0;

            if (accept) begin
                f3_q   <= FUNCT3;
                a_q    <= OPERAND_A;
                // Divides keep the divisor magnitude; multiplies need the raw value.
                b_q    <= FUNCT3[2] ? b_abs : OPERAND_B;
                // The dividend magnitude sits in the quotient register and shifts out
                // as quotient bits shift in.
                quo_q  <= a_abs;
                rem_q  <= 33'd0;
                cnt_q  <= DIV_ITERS_CNT;
                // With B=0 the iteration yields all-ones; suppressing the quotient
                // negation keeps that at -1 for negative dividends too.
                qneg_q <= (a_neg ^ b_neg) & ~b_zero;
                rneg_q <= a_neg;
`ifdef MULDIV_EARLY_OUT_EN
                if (early) begin
                    cnt_q <= 6'd0;
                    if (b_zero) begin
                        quo_q <= 32'hFFFF_FFFF;
                        rem_q <= {1'b0, a_abs};
                    end else begin
                        quo_q <= 32'h8000_0000;
                        rem_q <= 33'd0;
                    end
                end
`endif
            end

            if (do_step) begin
                rem_q <= rem_n;
                quo_q <= quo_n;
                cnt_q <= cnt_q - 6'd1;
            end

            if (fin_mul) result_q <= (f3_q == F3_MUL) ? prod[31:0] : prod[63:32];
            if (fin_div) result_q <= f3_q[1] ? rem_fix : quo_fix;
        end
    end

    assign RESULT = result_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed-vector bench for mul_div_unit.
// Honours MULDIV_EARLY_OUT_EN for the expected divide-by-zero / overflow latency.
module tb_mul_div_unit;
    import muldiv_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [2:0]  FUNCT3;
    logic [31:0] OPERAND_A, OPERAND_B;
    logic [31:0] RESULT;
    logic        BUSY, DONE;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_last = 32'd0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = 34;
`endif

    mul_div_unit #(.XLEN(32)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .FLUSH     (FLUSH),
        .FUNCT3    (FUNCT3),
        .OPERAND_A (OPERAND_A),
        .OPERAND_B (OPERAND_B),
        .RESULT    (RESULT),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    // Driver: issues one operation and waits (bounded) for DONE plus one cycle.
    // lat counts cycles from the START cycle through the DONE cycle (999 = timeout).
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] prev, output logic [31:0] res, output int lat,
                          output bit busy_ok, output bit pulse_ok, output bit hold_ok);
        int n;
        @(negedge CLK);
        START = 1'b1; FUNCT3 = f3; OPERAND_A = a; OPERAND_B = b;
        @(posedge CLK); #1;
        START = 1'b0;
        busy_ok = (BUSY === 1'b1);
        hold_ok = (RESULT === prev);
        n = 0;
        while (DONE !== 1'b1 && n < 60) begin
            @(posedge CLK); #1;
            n++;
            if (DONE !== 1'b1) begin
                busy_ok &= (BUSY === 1'b1);
                hold_ok &= (RESULT === prev);
            end
        end
        busy_ok &= (BUSY === 1'b1);
        res = RESULT;
        lat = (DONE === 1'b1) ? n + 1 : 999;
        @(posedge CLK); #1;
        pulse_ok = (DONE === 1'b0) && (BUSY === 1'b0) && (RESULT === res);
    endtask

    task automatic test_reset();
        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0; FUNCT3 = 3'd0;
        OPERAND_A = 32'd0; OPERAND_B = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        total++;
        if (RESULT !== 32'd0 || BUSY !== 1'b0 || DONE !== 1'b0)
            $display("FAIL reset_outputs: got result=%h busy=%b done=%b, expected 0/0/0", RESULT, BUSY, DONE);
        else passed++;
        @(negedge CLK); RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if (BUSY !== 1'b0 || DONE !== 1'b0)
            $display("FAIL post_reset_idle: got busy=%b done=%b, expected 0/0", BUSY, DONE);
        else passed++;
    endtask

    // Generic directed-vector runner used by the feature tests below.
    task automatic check_vec(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        logic [31:0] res; int lat; bit busy_ok, pulse_ok, hold_ok;
        run_op(f3, a, b, exp_last, res, lat, busy_ok, pulse_ok, hold_ok);
        total++;
        if (res !== exp_res) $display("FAIL %s_result: got %h expected %h", name, res, exp_res);
        else passed++;
        total++;
        if (lat != exp_lat) $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        else passed++;
        total++;
        if (!busy_ok || !hold_ok)
            $display("FAIL %s_busy_hold: got busy_ok=%0d hold_ok=%0d expected 1/1", name, busy_ok, hold_ok);
        else passed++;
        total++;
        if (!pulse_ok) $display("FAIL %s_done_pulse: got pulse_ok=%0d expected 1", name, pulse_ok);
        else passed++;
        exp_last = exp_res;
    endtask

    task automatic test_mul();
        check_vec("mul",    F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);
        check_vec("mulh",   F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        check_vec("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        check_vec("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        check_vec("mul_small", F3_MUL, 32'd1234, 32'd5678, 32'd7006652, 2);
    endtask

    task automatic test_div();
        check_vec("div_neg",  F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        check_vec("rem_neg",  F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        check_vec("divu_big", F3_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);
        check_vec("remu",     F3_REMU, 32'd100,       32'd7, 32'd2,         34);
    endtask

    task automatic test_div_zero();
        check_vec("div0",      F3_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        check_vec("remu0",     F3_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, SPECIAL_LAT);
        check_vec("divu0",     F3_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        check_vec("div0_neg",  F3_DIV,  32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, SPECIAL_LAT);
        check_vec("rem0_neg",  F3_REM,  32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, SPECIAL_LAT);
    endtask

    task automatic test_overflow();
        check_vec("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_LAT);
        check_vec("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPECIAL_LAT);
    endtask

    task automatic test_back_to_back();
        check_vec("b2b_mul", F3_MUL, 32'd6,  32'd7, 32'd42, 2);
        check_vec("b2b_div", F3_DIVU, 32'd42, 32'd5, 32'd8,  34);
        check_vec("b2b_mul2", F3_MULHU, 32'h8000_0000, 32'd4, 32'd2, 2);
    endtask

    task automatic test_flush();
        int dones;
        @(negedge CLK);
        START = 1'b1; FUNCT3 = F3_DIV; OPERAND_A = 32'd100; OPERAND_B = 32'd7;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (8) @(posedge CLK);
        @(negedge CLK); FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        total++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== exp_last)
            $display("FAIL flush_abort: got busy=%b done=%b result=%h expected 0/0/%h", BUSY, DONE, RESULT, exp_last);
        else passed++;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || RESULT !== exp_last)
            $display("FAIL flush_no_done: got dones=%0d result=%h expected 0/%h", dones, RESULT, exp_last);
        else passed++;
        check_vec("flush_then_mul", F3_MUL, 32'd3, 32'd5, 32'd15, 2);
    endtask

    task automatic test_flush_start();
        int dones;
        @(negedge CLK);
        START = 1'b1; FLUSH = 1'b1; FUNCT3 = F3_MUL; OPERAND_A = 32'd9; OPERAND_B = 32'd9;
        @(posedge CLK); #1;
        START = 1'b0; FLUSH = 1'b0;
        total++;
        if (BUSY !== 1'b0) $display("FAIL flush_start_busy: got %b expected 0", BUSY);
        else passed++;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || RESULT !== exp_last)
            $display("FAIL flush_start_dropped: got dones=%0d result=%h expected 0/%h", dones, RESULT, exp_last);
        else passed++;
    endtask

    task automatic test_start_ignored();
        int dones, first_lat;
        logic [31:0] first_res;
        dones = 0; first_lat = -1; first_res = 32'd0;
        @(negedge CLK);
        START = 1'b1; FUNCT3 = F3_DIV; OPERAND_A = 32'd100; OPERAND_B = 32'd7;
        @(posedge CLK); #1;
        START = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (c == 5) begin
                START = 1'b1; FUNCT3 = F3_MUL; OPERAND_A = 32'd3; OPERAND_B = 32'd5;
            end
            @(posedge CLK); #1;
            START = 1'b0;
            if (DONE === 1'b1) begin
                dones++;
                if (first_lat < 0) begin
                    first_lat = c + 1;
                    first_res = RESULT;
                end
            end
        end
        total++;
        if (dones != 1) $display("FAIL ignored_start_dones: got %0d expected 1", dones);
        else passed++;
        total++;
        if (first_res !== 32'd14) $display("FAIL ignored_start_result: got %h expected %h", first_res, 32'd14);
        else passed++;
        total++;
        if (first_lat != 34) $display("FAIL ignored_start_latency: got %0d expected 34", first_lat);
        else passed++;
        exp_last = 32'd14;
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        START = 1'b1; FUNCT3 = F3_DIVU; OPERAND_A = 32'd1000; OPERAND_B = 32'd3;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (5) @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        total++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 32'd0)
            $display("FAIL reset_mid: got busy=%b done=%b result=%h expected 0/0/0", BUSY, DONE, RESULT);
        else passed++;
        @(negedge CLK); RESET = 1'b0;
        exp_last = 32'd0;
        check_vec("after_reset_mul", F3_MUL, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 2);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_flush_start();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

- Multi-cycle RV32M execute unit.
- Performs MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU on two 32-bit operands.
- Drives one data input of the 32-bit 4-input result-select mux in the execute/writeback path; the pipeline stalls on `BUSY`.
- Multiply completes in 2 cycles; divide uses an iterative restoring divider with a 34-cycle latency.

## Interface
Parameters:
- `XLEN`, default 32, operand/result width; only 32 is supported.

Ports:
- `CLK` — input, 1 — single clock, rising edge.
- `RESET` — input, 1 — asynchronous reset, active-high.
- `START` — input, 1 — launch an operation; sampled only in IDLE.
- `FLUSH` — input, 1 — pipeline flush; abandons the in-flight operation.
- `FUNCT3` — input, 3 — M-extension funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `OPERAND_A` — input, 32 — rs1 value (multiplicand/dividend).
- `OPERAND_B` — input, 32 — rs2 value (multiplier/divisor).
- `RESULT` — output, 32 — registered result; holds until the next `DONE`.
- `BUSY` — output, 1 — high from the cycle after an accepted `START` until the cycle `DONE` is high, inclusive.
- `DONE` — output, 1 — one-cycle pulse marking `RESULT` valid.

## Operation
States: IDLE, MUL, DIV_RUN, DIV_FIX.

Launch and multiply:
- IDLE + `START` + !`FLUSH`: capture `FUNCT3` and both operands; go to MUL if `FUNCT3[2]`=0, else DIV_RUN.
- MUL: form the 64-bit product with per-op signedness.
  - MULHSU: A signed, B unsigned.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
  - Register `RESULT`, pulse `DONE`, go to IDLE.

Divide:
- Capture: for DIV/REM, record the absolute values of the operands and the sign flags (quotient sign = signA^signB, remainder sign = signA); DIVU/REMU use the raw operands. Load the 6-bit iteration counter with 32.
- DIV_RUN: one restoring step per cycle (shift remainder:quotient left, trial-subtract the divisor, set the quotient bit). Decrement the counter; go to DIV_FIX when it reaches 0.
- DIV_FIX: apply sign correction, register `RESULT` (quotient for DIV/DIVU, remainder for REM/REMU), pulse `DONE`, go to IDLE.

Boundary rules:
- Divide by zero (B=0): quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = A.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- Both special cases fall out of the iteration plus sign fix without being detected, unless early-out is enabled (see Configuration).
- `START` while not IDLE: ignored; no queueing.
- `FLUSH` in any non-IDLE state: next state is IDLE, `BUSY`=0, no `DONE`, `RESULT` unchanged.
- `FLUSH` and `START` in the same IDLE cycle: `FLUSH` wins and the start is dropped.
- `RESET` mid-operation: immediate return to IDLE; all outputs take their reset values.

## Timing
- Reset values: `RESULT`=0, `BUSY`=0, `DONE`=0, state IDLE, counter 0.
- `START` sampled at edge k; `BUSY`=1 after edge k.
- MUL: `DONE`=1 and `RESULT` valid after edge k+1, so latency is 2 cycles counting the `START` cycle.
- DIV: DIV_RUN spans edges k+1 through k+32; DIV_FIX asserts `DONE` after edge k+33.
- `BUSY` drops after the edge following `DONE`.
- Back-to-back: a new `START` is accepted in the cycle after `DONE`.
- `DONE` never lasts more than one cycle. `RESULT` changes only on the edge that raises `DONE`.

## Configuration
Macro: `MULDIV_EARLY_OUT_EN`.
- Defined: in the capture cycle, detect B=0 or signed overflow and go directly to DIV_FIX with the architected result preloaded. These cases then finish with multiply latency (`DONE` after edge k+1).
- Undefined: every divide takes the full 34 cycles.
- Results are identical either way; only latency differs.

## Structure
- Package `muldiv_pkg` holds:
  - funct3 localparams (`F3_MUL` … `F3_REMU`)
  - the state encoding (IDLE=2'b00, MUL=2'b01, DIV_RUN=2'b10, DIV_FIX=2'b11)
  - the constant `DIV_ITERS`=32
- One sub-module, `div_step`: combinational single restoring-division iteration.
  - Inputs: 33-bit partial remainder, 32-bit quotient, 32-bit divisor.
  - Outputs: next remainder, next quotient.
  - Instantiated once.

## Test plan
- MUL A=0xFFFFFFFF, B=0xFFFFFFFF: MUL → 0x00000001, MULH → 0x00000000, MULHU → 0xFFFFFFFE, MULHSU → 0xFFFFFFFF; each `DONE` arrives 2 cycles after `START`.
- DIV A=-7 (0xFFFFFFF9), B=2: DIV → 0xFFFFFFFD, REM → 0xFFFFFFFF, DIVU → 0x7FFFFFFC; `DONE` exactly 34 cycles after `START`; `BUSY` high throughout.
- Divide by zero A=0x12345678, B=0: DIV → 0xFFFFFFFF, REMU → 0x12345678. Latency is 34 cycles, or 2 with `MULDIV_EARLY_OUT_EN`.
- Overflow A=0x80000000, B=0xFFFFFFFF: DIV → 0x80000000, REM → 0x00000000.
- `FLUSH` at cycle 10 of a DIV, then `START` MUL 3×5: no `DONE` for the divide; next `DONE` gives 15; `RESULT` keeps its old value until then.
- `START` pulsed while `BUSY` (DIV 100/7 running): the second `START` is ignored; a single `DONE` returns 14. Assert `RESET` during a later DIV: `BUSY`, `DONE` and `RESULT` go to 0 immediately.
